div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
Parametrised multi-cycle integer divider, the successor to the CPU's fixed 32-bit unsigned shift-subtract divider. It adds configurable width, a runtime signed/unsigned mode and a start/busy/done handshake. Divide-by-zero is reported as a registered flag with defined results. It sits beside the multiplier in the ALU complex and writes HI (remainder) and LO (quotient).

Parameters:
WIDTH, 32, operand/result width in bits (>= 4)
SIGNED_EN, 1, 1 = honour is_signed input; 0 = is_signed ignored, always unsigned

Ports:
clock  in  1  system clock
reset  in  1  reset, synchronous, active-high
start  in  1  request; sampled only when busy=0
is_signed  in  1  1 = two's-complement division (when SIGNED_EN=1)
dividend  in  WIDTH  numerator, sampled with accepted start
divisor  in  WIDTH  denominator, sampled with accepted start
busy  out  1  operation in progress
done  out  1  one-cycle pulse, results valid
div_by_zero  out  1  last operation had divisor==0; held until next accepted start
quotient  out  WIDTH  result to LO
remainder  out  WIDTH  result to HI

Behaviour:
- Reset (wins over start): state IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0.
- Reset mid-operation aborts it; no done pulse; outputs return to reset values.
- FSM states: IDLE, CALC, FIX, DZERO.
- IDLE + start=1 -> latch operands and mode, clear div_by_zero, busy=1.
  - divisor==0 -> DZERO.
  - otherwise -> CALC with iteration counter = WIDTH-1.
- start while busy=1 is ignored; operands are not re-sampled.
- Operand conditioning on accept (signed mode): store |dividend| and |divisor| as unsigned WIDTH-bit values. Record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
- CALC, one restoring step per cycle, WIDTH cycles total:
  - trial = {rem[WIDTH-2:0], q[WIDTH-1]} - d, computed at WIDTH+1 bits.
  - If trial is non-negative: rem = trial, shift 1 into q.
  - Otherwise: rem = shifted value, shift 0 into q.
  - When counter==0 -> FIX; else decrement counter.
- FIX (1 cycle): quotient = neg_q ? -q : q; remainder = neg_r ? -rem : rem. done=1 and busy=0 for this cycle -> IDLE.
- DZERO (1 cycle): quotient = all ones; remainder = dividend as supplied (unmodified); div_by_zero=1; done=1; busy=0 -> IDLE.
- Latency from the start edge to the done cycle:
  - normal: WIDTH+1 cycles (WIDTH CALC + 1 FIX edge); done visible in the cycle after edge WIDTH+1.
  - divide by zero: 1 cycle.
- Back-to-back: start may be asserted in the done cycle and is accepted at the next edge.
- Signed overflow MIN / -1: quotient = MIN, remainder = 0, no flag. This falls out of the unsigned magnitude path.
- quotient, remainder and div_by_zero hold their values between operations; they change only on FIX, DZERO, accepted start (div_by_zero only) or reset.
- Unsigned results satisfy dividend = quotient*divisor + remainder with remainder < divisor. Signed results truncate toward zero.

Decomposition:
- Package div_pkg: state enum (IDLE, CALC, FIX, DZERO), counter width function clog2(WIDTH), results-on-zero constant (all ones).
- Sub-module div_sign_adjust (combinational, parametrised WIDTH): conditional two's-complement negate. Instantiated for operand magnitude and for result fix-up.
- Control FSM and datapath stay in div_seq.

Test Plan:
- WIDTH=32, unsigned 100/7 -> done exactly 33 cycles after start edge; quotient=14, remainder=2, div_by_zero=0.
- WIDTH=32, signed -7/2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); 7/-2 -> quotient=-3, remainder=1.
- WIDTH=32, signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
- 0x1234/0 -> done 1 cycle after start; div_by_zero=1, quotient=0xFFFFFFFF, remainder=0x1234. Flag holds until the next accepted start, then clears.
- Start with 50/5, pulse start with 9/3 at cycle 10 (ignored) -> result 10 r0. Then reset at cycle 5 of a new op -> no done pulse, all outputs 0, next 9/3 gives 3 r0.
- WIDTH=8, SIGNED_EN=1:
  - unsigned 200/3 -> 66 r2, done after 9 cycles.
  - signed 0xC8(-56)/3 -> quotient 0xEE (-18), remainder 0xFE (-2).
  - SIGNED_EN=0 with is_signed=1 -> 200/3 unsigned result.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider: FSM state encoding,
// counter sizing and the quotient fill value used on divide-by-zero.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIX   = 2'd2,
    DZERO = 2'd3
  } state_t;

  // Every quotient bit takes this value when the divisor is zero.
  localparam logic DZ_FILL_BIT = 1'b1;

  // Bits needed to count from value-1 down to 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle between the ALU issue logic (master) and div_seq (slave).
interface div_seq_if
  import div_pkg::*;
#(
  parameter int WIDTH = 32
);

  // Handshake: a request is accepted on a rising clock edge where start=1 and
  // busy=0; operands and is_signed are sampled on that edge only. busy stays
  // high until the result is written, and done pulses for exactly one cycle
  // (with busy=0) while quotient/remainder/div_by_zero carry the new result.
  // start raised in the done cycle is accepted on the following edge.
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  state_t           dbg_state;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, div_by_zero, quotient, remainder, dbg_state
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, div_by_zero, quotient, remainder, dbg_state
  );

endinterface

// File: rtl/div_sign_adjust.sv
// Conditional two's-complement negation: result = neg ? -value : value.
module div_sign_adjust #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] result
);

  assign result = neg ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider, one quotient bit per cycle, with optional
// signed mode handled by magnitude conversion before and sign fix-up after.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  div_seq_if.slave   bus
);

  localparam int CW = clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] a_raw;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dz_r;
  logic             done_r;
  logic             busy_c;

  logic             mode_signed;
  logic             a_neg;
  logic             b_neg;
  logic             accept;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;

  assign mode_signed = SIGNED_EN && bus.is_signed;
  assign a_neg       = mode_signed & bus.dividend[WIDTH-1];
  assign b_neg       = mode_signed & bus.divisor[WIDTH-1];
  assign accept      = (state == IDLE) && bus.start;

  div_sign_adjust #(.WIDTH(WIDTH)) u_mag_a (
    .neg(a_neg), .value(bus.dividend), .result(a_mag)
  );
  div_sign_adjust #(.WIDTH(WIDTH)) u_mag_b (
    .neg(b_neg), .value(bus.divisor), .result(b_mag)
  );
  div_sign_adjust #(.WIDTH(WIDTH)) u_fix_q (
    .neg(neg_q), .value(q), .result(q_fix)
  );
  div_sign_adjust #(.WIDTH(WIDTH)) u_fix_r (
    .neg(neg_r), .value(rem), .result(r_fix)
  );

  // Partial remainder is always below 2^(WIDTH-1) before a shift, so its MSB
  // can be dropped; q doubles as the dividend shift register.
  assign shifted = {rem[WIDTH-2:0], q[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {1'b0, d};

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (bus.start) state_nxt = (bus.divisor == '0) ? DZERO : CALC;
      CALC:  if (cnt == '0) state_nxt = FIX;
      FIX:   state_nxt = IDLE;
      DZERO: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_c = 1'b0;
    if (state != IDLE) busy_c = 1'b1;
  end

  // Datapath and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt         <= '0;
      q           <= '0;
      rem         <= '0;
      d           <= '0;
      a_raw       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dz_r        <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            q     <= a_mag;
            rem   <= '0;
            d     <= b_mag;
            a_raw <= bus.dividend;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            cnt   <= CW'(WIDTH - 1);
            dz_r  <= 1'b0;
          end
        end
        CALC: begin
          q   <= {q[WIDTH-2:0], ~trial[WIDTH]};
          rem <= trial[WIDTH] ? shifted : trial[WIDTH-1:0];
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          quotient_r  <= q_fix;
          remainder_r <= r_fix;
          done_r      <= 1'b1;
        end
        DZERO: begin
          quotient_r  <= {WIDTH{DZ_FILL_BIT}};
          remainder_r <= a_raw;
          dz_r        <= 1'b1;
          done_r      <= 1'b1;
        end
      endcase
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dz_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: 32-bit signed-capable, 8-bit signed-capable and 8-bit
// unsigned-only instances checked against an arithmetic reference model.
module tb_div_seq;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_bad;

  div_seq_if #(.WIDTH(32)) b32 ();
  div_seq_if #(.WIDTH(8))  b8 ();
  div_seq_if #(.WIDTH(8))  b8u ();

  div_seq #(.WIDTH(32), .SIGNED_EN(1'b1)) u32 (.clock(clock), .reset(reset), .bus(b32));
  div_seq #(.WIDTH(8),  .SIGNED_EN(1'b1)) u8  (.clock(clock), .reset(reset), .bus(b8));
  div_seq #(.WIDTH(8),  .SIGNED_EN(1'b0)) u8u (.clock(clock), .reset(reset), .bus(b8u));

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic on sign-extended values, truncating
  // toward zero; divide-by-zero gives all ones and the original dividend.
  function automatic void ref_div(input int w, input bit sgn,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, mask;
    mask = (longint'(1) << w) - 1;
    if (b == 0) begin
      q = 32'(mask);
      r = a;
      return;
    end
    sa = longint'(a);
    sb = longint'(b);
    if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
    q = 32'((sa / sb) & mask);
    r = 32'((sa % sb) & mask);
  endfunction

  // drivers: called mid-cycle, return #1 after the edge that shows done
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                      output logic [31:0] q, output logic [31:0] r,
                      output logic dz, output int lat);
    b32.start = 1'b1; b32.dividend = a; b32.divisor = b; b32.is_signed = sgn;
    @(posedge clock); #1;
    b32.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock); #1;
      if (b32.done === 1'b1) begin lat = k; break; end
    end
    q = b32.quotient; r = b32.remainder; dz = b32.div_by_zero;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit sgn,
                     output logic [7:0] qs, output logic [7:0] rs, output int lat_s,
                     output logic [7:0] qu, output logic [7:0] ru, output int lat_u);
    b8.start = 1'b1;  b8.dividend = a;  b8.divisor = b;  b8.is_signed = sgn;
    b8u.start = 1'b1; b8u.dividend = a; b8u.divisor = b; b8u.is_signed = sgn;
    @(posedge clock); #1;
    b8.start = 1'b0; b8u.start = 1'b0;
    lat_s = -1; lat_u = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock); #1;
      if (b8.done === 1'b1 && lat_s < 0) lat_s = k;
      if (b8u.done === 1'b1 && lat_u < 0) lat_u = k;
      if (lat_s >= 0 && lat_u >= 0) break;
    end
    qs = b8.quotient; rs = b8.remainder; qu = b8u.quotient; ru = b8u.remainder;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    b32.start = 0; b32.is_signed = 0; b32.dividend = 0; b32.divisor = 0;
    b8.start = 0;  b8.is_signed = 0;  b8.dividend = 0;  b8.divisor = 0;
    b8u.start = 0; b8u.is_signed = 0; b8u.dividend = 0; b8u.divisor = 0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if ({b32.busy, b32.done, b32.div_by_zero} !== 3'b000) begin
      n_bad++; $display("FAIL reset32_flags got %b want 000", {b32.busy, b32.done, b32.div_by_zero});
    end
    n_cmp++;
    if ({b32.quotient, b32.remainder} !== 64'd0) begin
      n_bad++; $display("FAIL reset32_results got %h %h want 0 0", b32.quotient, b32.remainder);
    end
    n_cmp++;
    if ({b8.busy, b8.done, b8.div_by_zero, b8.quotient, b8.remainder} !== 19'd0) begin
      n_bad++; $display("FAIL reset8 got %b %h %h want all 0",
                        {b8.busy, b8.done, b8.div_by_zero}, b8.quotient, b8.remainder);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed32();
    logic [31:0] ta [6] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd5};
    logic [31:0] tb [6] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'd7};
    bit          ts [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] tq [6] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] tr [6] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd5};
    logic [31:0] q, r;
    logic dz;
    int lat;
    for (int i = 0; i < 6; i++) begin
      op32(ta[i], tb[i], ts[i], q, r, dz, lat);
      n_cmp++;
      if (q !== tq[i] || r !== tr[i]) begin
        n_bad++; $display("FAIL dir32_result[%0d] got q=%h r=%h want q=%h r=%h", i, q, r, tq[i], tr[i]);
      end
      n_cmp++;
      if (dz !== 1'b0 || lat !== 33) begin
        n_bad++; $display("FAIL dir32_timing[%0d] got dz=%b lat=%0d want dz=0 lat=33", i, dz, lat);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] q, r;
    logic dz;
    int lat;
    op32(32'h1234, 32'd0, 1'b1, q, r, dz, lat);
    n_cmp++;
    if (q !== 32'hFFFF_FFFF || r !== 32'h1234 || dz !== 1'b1) begin
      n_bad++; $display("FAIL dz_result got q=%h r=%h dz=%b want ffffffff 1234 1", q, r, dz);
    end
    n_cmp++;
    if (lat !== 1) begin n_bad++; $display("FAIL dz_latency got %0d want 1", lat); end
    repeat (5) @(posedge clock);
    #1;
    n_cmp++;
    if (b32.div_by_zero !== 1'b1 || b32.quotient !== 32'hFFFF_FFFF || b32.remainder !== 32'h1234) begin
      n_bad++; $display("FAIL dz_hold got dz=%b q=%h r=%h want 1 ffffffff 1234",
                        b32.div_by_zero, b32.quotient, b32.remainder);
    end
    b32.start = 1'b1; b32.dividend = 32'd9; b32.divisor = 32'd3; b32.is_signed = 1'b0;
    @(posedge clock); #1;
    b32.start = 1'b0;
    n_cmp++;
    if (b32.div_by_zero !== 1'b0 || b32.busy !== 1'b1) begin
      n_bad++; $display("FAIL dz_clear got dz=%b busy=%b want 0 1", b32.div_by_zero, b32.busy);
    end
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock); #1;
      if (b32.done === 1'b1) begin lat = k; break; end
    end
    n_cmp++;
    if (b32.quotient !== 32'd3 || b32.remainder !== 32'd0 || lat !== 33) begin
      n_bad++; $display("FAIL dz_next got q=%h r=%h lat=%0d want 3 0 33", b32.quotient, b32.remainder, lat);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    b32.start = 1'b1; b32.dividend = 32'd50; b32.divisor = 32'd5; b32.is_signed = 1'b0;
    @(posedge clock); #1;
    b32.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      if (k == 10) begin b32.start = 1'b1; b32.dividend = 32'd9; b32.divisor = 32'd3; end
      if (k == 11) b32.start = 1'b0;
      @(posedge clock); #1;
      if (b32.done === 1'b1) begin lat = k; break; end
    end
    n_cmp++;
    if (b32.quotient !== 32'd10 || b32.remainder !== 32'd0 || lat !== 33) begin
      n_bad++; $display("FAIL ignore_start got q=%h r=%h lat=%0d want 10 0 33",
                        b32.quotient, b32.remainder, lat);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] q, r;
    logic dz;
    int lat, seen;
    b32.start = 1'b1; b32.dividend = 32'd1000; b32.divisor = 32'd7; b32.is_signed = 1'b0;
    @(posedge clock); #1;
    b32.start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_cmp++;
    if ({b32.busy, b32.done, b32.div_by_zero, b32.quotient, b32.remainder} !== 67'd0) begin
      n_bad++; $display("FAIL abort_outputs got busy=%b done=%b dz=%b q=%h r=%h want all 0",
                        b32.busy, b32.done, b32.div_by_zero, b32.quotient, b32.remainder);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (b32.done !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL abort_no_done got %0d done cycles want 0", seen); end
    op32(32'd9, 32'd3, 1'b0, q, r, dz, lat);
    n_cmp++;
    if (q !== 32'd3 || r !== 32'd0 || lat !== 33) begin
      n_bad++; $display("FAIL abort_next got q=%h r=%h lat=%0d want 3 0 33", q, r, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q, r;
    logic dz;
    int lat;
    op32(32'd1000, 32'd10, 1'b0, q, r, dz, lat);
    n_cmp++;
    if (b32.done !== 1'b1 || b32.busy !== 1'b0) begin
      n_bad++; $display("FAIL b2b_done_cycle got done=%b busy=%b want 1 0", b32.done, b32.busy);
    end
    op32(32'hFFFF_FF9C, 32'd10, 1'b1, q, r, dz, lat);
    n_cmp++;
    if (q !== 32'hFFFF_FFF6 || r !== 32'd0 || lat !== 33) begin
      n_bad++; $display("FAIL b2b_second got q=%h r=%h lat=%0d want fffffff6 0 33", q, r, lat);
    end
  endtask

  task automatic test_random32();
    logic [31:0] a, b, q, r, eq, er;
    logic dz;
    bit sgn;
    int lat;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = 32'($urandom_range(0, 1000));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      sgn = 1'($urandom_range(0, 1));
      ref_div(32, sgn, a, b, eq, er);
      op32(a, b, sgn, q, r, dz, lat);
      n_cmp++;
      if (q !== eq || r !== er) begin
        n_bad++; $display("FAIL rnd32 a=%h b=%h s=%0d got q=%h r=%h want q=%h r=%h", a, b, sgn, q, r, eq, er);
      end
      n_cmp++;
      if (dz !== (b == 0) || lat !== ((b == 0) ? 1 : 33)) begin
        n_bad++; $display("FAIL rnd32_flag a=%h b=%h got dz=%b lat=%0d want dz=%b lat=%0d",
                          a, b, dz, lat, (b == 0), (b == 0) ? 1 : 33);
      end
    end
  endtask

  task automatic test_width8();
    logic [7:0] a, b, qs, rs, qu, ru;
    logic [31:0] eqs, ers, equ, eru;
    bit sgn;
    int ls, lu;
    op8(8'd200, 8'd3, 1'b0, qs, rs, ls, qu, ru, lu);
    n_cmp++;
    if (qs !== 8'd66 || rs !== 8'd2 || ls !== 9) begin
      n_bad++; $display("FAIL w8_unsigned got q=%h r=%h lat=%0d want 42 02 9", qs, rs, ls);
    end
    op8(8'hC8, 8'd3, 1'b1, qs, rs, ls, qu, ru, lu);
    n_cmp++;
    if (qs !== 8'hEE || rs !== 8'hFE || ls !== 9) begin
      n_bad++; $display("FAIL w8_signed got q=%h r=%h lat=%0d want ee fe 9", qs, rs, ls);
    end
    n_cmp++;
    if (qu !== 8'd66 || ru !== 8'd2 || lu !== 9) begin
      n_bad++; $display("FAIL w8_signed_disabled got q=%h r=%h lat=%0d want 42 02 9", qu, ru, lu);
    end
    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (i == 0) begin a = 8'h80; b = 8'hFF; end
      sgn = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      ref_div(8, sgn, {24'd0, a}, {24'd0, b}, eqs, ers);
      ref_div(8, 1'b0, {24'd0, a}, {24'd0, b}, equ, eru);
      op8(a, b, sgn, qs, rs, ls, qu, ru, lu);
      n_cmp++;
      if (qs !== eqs[7:0] || rs !== ers[7:0] || ls !== ((b == 0) ? 1 : 9)) begin
        n_bad++; $display("FAIL rnd8_signed a=%h b=%h s=%0d got q=%h r=%h lat=%0d want q=%h r=%h",
                          a, b, sgn, qs, rs, ls, eqs[7:0], ers[7:0]);
      end
      n_cmp++;
      if (qu !== equ[7:0] || ru !== eru[7:0] || b8u.div_by_zero !== (b == 0)) begin
        n_bad++; $display("FAIL rnd8_unsigned a=%h b=%h got q=%h r=%h dz=%b want q=%h r=%h",
                          a, b, qu, ru, b8u.div_by_zero, equ[7:0], eru[7:0]);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_directed32();
    test_div_zero();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random32();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
